// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and data-bus signal bundle for the load/store unit
//
// slave  : the LSU side (takes requests, drives responses and the bus request)
// master : the core/memory side (drives requests and bus responses)
//
// start/instruction/addr/store_data : request from execute
// busy/done/load_data/fault/fault_cause : response to writeback
// mem_valid/mem_addr/mem_wdata/mem_wstrb : bus request
// mem_ready/mem_rdata                     : bus response
interface lsu_if;
    logic        start;
    logic [31:0] instruction;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, instruction, addr, store_data, mem_ready, mem_rdata,
        output busy, done, load_data, fault, fault_cause,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output start, instruction, addr, store_data, mem_ready, mem_rdata,
        input  busy, done, load_data, fault, fault_cause,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with access checking and bus timeout
//
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_if.slave - request from execute, response to writeback,
//           single valid/ready transaction on a 32-bit word-addressed bus
// Parameter BUS_TIMEOUT: BUS cycles without mem_ready before a timeout fault
//   (0 disables the timeout).
module lsu #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW:0] LIMIT = (CW + 1)'(BUS_TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic        load_q, load_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] ldata_q, ldata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    // Request decode, evaluated only when a start is accepted in IDLE.
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        is_load, is_store, illegal, misal;
    assign f3       = bus.instruction[14:12];
    assign opc      = bus.instruction[6:0];
    assign is_load  = (opc == 7'b0000011);
    assign is_store = (opc == 7'b0100011);
    assign illegal  = !(is_load || is_store)
                    || (is_load && (f3 == 3'b011 || f3[2:1] == 2'b11))
                    || (is_store && f3 > 3'b010);
    // f3[1:0] encodes the access size for every legal load/store.
    assign misal    = (f3[1:0] == 2'b01 && bus.addr[0])
                    || (f3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);

    // Lane selection for read data, using the offset captured at start.
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    always_comb begin
        byte_lane = bus.mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_lane = bus.mem_rdata[15:8];
            2'd2:    byte_lane = bus.mem_rdata[23:16];
            2'd3:    byte_lane = bus.mem_rdata[31:24];
            default: byte_lane = bus.mem_rdata[7:0];
        endcase
    end
    assign half_lane = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    logic [CW:0] cnt_inc;
    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        load_d  = load_q;
        off_d   = off_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ldata_d = ldata_q;
        fault_d = fault_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ldata_d = 32'd0;
                    fault_d = 1'b0;
                    cause_d = 2'd0;
                    f3_d    = f3;
                    load_d  = is_load;
                    off_d   = bus.addr[1:0];
                    if (illegal) begin
                        fault_d = 1'b1;
                        cause_d = 2'd3;
                        state_d = RESP;
                    end else if (misal) begin
                        fault_d = 1'b1;
                        cause_d = 2'd1;
                        state_d = RESP;
                    end else begin
                        state_d = BUS;
                        cnt_d   = '0;
                        maddr_d = {bus.addr[31:2], 2'b00};
                        wdata_d = 32'd0;
                        wstrb_d = 4'b0000;
                        if (is_store) begin
                            case (f3[1:0])
                                2'b00: begin
                                    wdata_d = {4{bus.store_data[7:0]}};
                                    wstrb_d = 4'b0001 << bus.addr[1:0];
                                end
                                2'b01: begin
                                    wdata_d = {2{bus.store_data[15:0]}};
                                    wstrb_d = 4'b0011 << bus.addr[1:0];
                                end
                                default: begin
                                    wdata_d = bus.store_data;
                                    wstrb_d = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
            end
            BUS: begin
                // Ready is tested first so it wins over a same-cycle timeout.
                if (bus.mem_ready) begin
                    state_d = RESP;
                    if (load_q) begin
                        case (f3_q)
                            3'b000:  ldata_d = {{24{byte_lane[7]}}, byte_lane};
                            3'b100:  ldata_d = {24'd0, byte_lane};
                            3'b001:  ldata_d = {{16{half_lane[15]}}, half_lane};
                            3'b101:  ldata_d = {16'd0, half_lane};
                            default: ldata_d = bus.mem_rdata;
                        endcase
                    end
                end else if (BUS_TIMEOUT != 0) begin
                    cnt_d = cnt_inc[CW-1:0];
                    if (cnt_inc == LIMIT) begin
                        fault_d = 1'b1;
                        cause_d = 2'd2;
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= 3'd0;
            load_q  <= 1'b0;
            off_q   <= 2'd0;
            maddr_q <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ldata_q <= 32'd0;
            fault_q <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
            off_q   <= off_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ldata_q <= ldata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    // mem_valid is decoded from state so an async reset drops it at once.
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == RESP);
    assign bus.mem_valid   = (state_q == BUS);
    assign bus.mem_addr    = maddr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = wstrb_q;
    assign bus.load_data   = ldata_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.instruction[31:15], bus.instruction[11:7]};
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core, directly downstream of the ALU. On a LOAD or STORE in execute it takes the ALU's effective-address result and rs2. It runs one valid/ready transaction on the data bus and returns sign-/zero-extended load data or a fault to writeback. It formats byte and halfword accesses onto a 32-bit word-addressed bus and detects misaligned accesses, illegal funct3 values and bus timeouts.

## Interface
- BUS_TIMEOUT, 255: max cycles mem_valid may stay high without mem_ready before a timeout fault; 0 disables the timeout.

- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- instruction  in  32  LOAD/STORE instruction; opcode [6:0], funct3 [14:12]
- addr  in  32  effective address (ALU result: rs1 + I/S immediate)
- store_data  in  32  rs2 value
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- load_data  out  32  formatted load result; valid while done=1
- fault  out  1  valid while done=1
- fault_cause  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal funct3/opcode
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accept; for reads, mem_rdata is valid in the same cycle
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 4'b0000 for reads
- mem_rdata  in  32  read data

## Operation
- States: IDLE, BUS, RESP.
- IDLE + start:
  - Register instruction, addr and store_data. Upstream may change them afterwards.
  - Check the access:
    - Opcode not LOAD (0000011) or STORE (0100011) → cause 3.
    - Load funct3 in {011,110,111} or store funct3 > 010 → cause 3.
    - Halfword with addr[0]=1 → cause 1.
    - Word with addr[1:0]!=0 → cause 1.
  - Any fault → RESP. No bus activity.
  - Otherwise → BUS with mem_valid=1.
- BUS:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready is sampled high.
  - mem_ready=1 → capture and format the read data, drop mem_valid, go to RESP.
  - Timeout counter increments each BUS cycle without ready. When it reaches BUS_TIMEOUT: drop mem_valid, go to RESP with cause 2.
  - mem_ready in the same cycle the counter reaches the limit → ready wins, no fault.
- RESP: done=1 for exactly one cycle, then go to IDLE.
- start asserted while busy is ignored; no queueing.
- Store formatting, with o = addr[1:0]:
  - SB: wdata = 4 copies of byte; wstrb = 4'b0001<<o.
  - SH: wdata = 2 copies of halfword; wstrb = 4'b0011<<o.
  - SW: wdata = data; wstrb = 4'b1111.
- Load formatting:
  - Byte lane = rdata[8*o +: 8]; halfword lane = rdata[16*o[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- load_data = 0 on stores and on any fault.
- Counter width is sized to hold BUS_TIMEOUT; the counter clears on entry to BUS.

## Timing
- Reset (async assert): state=IDLE; busy, done, fault, mem_valid = 0; fault_cause=0; load_data, mem_addr, mem_wdata, mem_wstrb = 0; counter=0. Release is synchronous to clk.
- Reset mid-transaction: mem_valid drops immediately. No done pulse is produced.
- start sampled at edge k, mem_ready=1 at edge k+1: done=1 between edges k+1 and k+2. Minimum latency is 2 cycles.
- Each extra wait-state cycle adds 1 cycle of latency.
- Fault at start (edge k): done=1, fault=1 between edges k and k+1. mem_valid never rises.
- Timeout: mem_valid is high for exactly BUS_TIMEOUT cycles, then done+fault on the following cycle.
- busy is high from the cycle after accepting start through the done cycle inclusive. A new start is accepted on the edge where done is high is NOT allowed; the earliest is the next edge.

## Test plan
- LW at addr 0x100, store_data=X, mem_ready on first BUS cycle, rdata 0xDEADBEEF → mem_addr 0x100, wstrb 0000, done 2 cycles after start, load_data 0xDEADBEEF, fault 0.
- LB at addr 0x203, rdata 0x80112233 → mem_addr 0x200, load_data 0xFFFFFF80. Same access as LBU → 0x00000080.
- SH at addr 0x302, store_data 0x0000ABCD → mem_wdata 0xABCDABCD, wstrb 1100, mem_addr 0x300. With 3 wait states, done follows 5 cycles after start.
- LH at 0x101 → done+fault on the cycle after start, cause 1, mem_valid never high. Load funct3 111 → cause 3.
- BUS_TIMEOUT=4, mem_ready held 0 → mem_valid high exactly 4 cycles, then done, fault, cause 2. Repeat with ready in the 4th cycle → no fault.
- rst_n pulsed low during BUS → mem_valid and busy go low asynchronously, no done. A new LW after release completes normally. start pulsed while busy → ignored.
